// File: rtl/runner_master_pkg.sv
// Shared types and constants for the running-light / SPI master block.
package runner_master_pkg;

    localparam int REG_WIDTH_DEF = 8;
    localparam int LED_WIDTH_DEF = 6;
    localparam int CLK_DIV_DEF   = 4;

    localparam logic [5:0] LED_RESET = 6'b000001;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } spi_state_t;

endpackage

// File: rtl/runner_master_spi_master_core.sv
// SPI mode-0 master, LSB first: one frame of REG_WIDTH bits per start pulse.
// All outputs are registered; the received byte lands in rx_data at DONE.
module spi_master_core
    import runner_master_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_DEF,
    parameter int LED_WIDTH = LED_WIDTH_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LED_WIDTH-1:0] pattern,
    input  logic                 miso,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi,
    output logic [REG_WIDTH-1:0] rx_data
);

    localparam int CNT_W = (REG_WIDTH > 1) ? $clog2(REG_WIDTH) : 1;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REG_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    spi_state_t           state;
    logic [REG_WIDTH-1:0] tx_shift;
    logic [REG_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_W-1:0]     bit_nxt;

    assign bit_nxt = bit_cnt + CNT_W'(1);

    // Frame FSM: divider, bit counter, shift registers and registered SPI pins.
    // cs/mosi are set on the edge entering LOAD so they are valid during LOAD,
    // and cs is released on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cs       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cs   <= 1'b1;
                    sclk <= 1'b0;
                    if (start) begin
                        tx_shift <= REG_WIDTH'(pattern);
                        cs       <= 1'b0;
                        mosi     <= pattern[0];
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt           <= '0;
                        sclk              <= 1'b1;
                        rx_shift[bit_cnt] <= miso;
                        state             <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (bit_cnt == CNT_LAST) begin
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_nxt;
                            mosi    <= tx_shift[bit_nxt];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    rx_data <= rx_shift;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/runner_master.sv
// Running light with button synchronizers; frames the pattern out over SPI.
module runner_master
    import runner_master_pkg::*;
#(
    parameter int REG_WIDTH = REG_WIDTH_DEF,
    parameter int LED_WIDTH = LED_WIDTH_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    input  logic                 t_start,
    input  logic                 up,
    output logic [LED_WIDTH-1:0] led,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso
);

    // Two synchronizer stages plus one history stage per button.
    logic [2:0] up_sync;
    logic [2:0] st_sync;
    logic       up_press;
    logic       st_press;
    logic [REG_WIDTH-1:0] rx_data;

    // Button synchronizers; idle high so reset does not fake a press.
    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            up_sync <= 3'b111;
            st_sync <= 3'b111;
        end else begin
            up_sync <= {up_sync[1:0], up};
            st_sync <= {st_sync[1:0], t_start};
        end
    end

    // Falling edge of the synchronized level = one press, however long the hold.
    assign up_press = up_sync[2] & ~up_sync[1];
    assign st_press = st_sync[2] & ~st_sync[1];

    // LED rotator: left rotate with wrap on each up press.
    always_ff @(posedge sys_clk) begin
        if (rstn) begin
            led <= LED_WIDTH'(LED_RESET);
        end else if (up_press) begin
            led <= {led[LED_WIDTH-2:0], led[LED_WIDTH-1]};
        end
    end

    // Core latches led on the same edge it rotates, so a simultaneous
    // press sends the pre-rotation pattern.
    spi_master_core #(
        .REG_WIDTH (REG_WIDTH),
        .LED_WIDTH (LED_WIDTH),
        .CLK_DIV   (CLK_DIV)
    ) u_spi (
        .clk     (sys_clk),
        .rst     (rstn),
        .start   (st_press),
        .pattern (led),
        .miso    (miso),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi),
        .rx_data (rx_data)
    );

endmodule

// File: tb/tb_runner_master.sv
// Bench for runner_master: directed stimulus, SPI frames checked by a
// scoreboard monitor, slave model returns a chosen byte on miso.
module tb_runner_master;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } frame_t;

    logic       sys_clk = 1'b0;
    logic       rstn    = 1'b1;
    logic       t_start = 1'b1;
    logic       up      = 1'b1;
    logic       miso    = 1'b0;
    logic [5:0] led;
    logic       cs, sclk, mosi;

    int checks = 0;
    int errors = 0;

    frame_t     sb[$];
    logic [7:0] slave_byte = 8'h00;
    int         sidx = 0;

    // monitor state
    logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
    logic       in_frame = 1'b0;
    logic [7:0] bits;
    int         nrise = 0, low_cnt = 0;
    logic       rx_pend = 1'b0;
    logic [7:0] rx_exp;

    runner_master dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .t_start (t_start),
        .up      (up),
        .led     (led),
        .cs      (cs),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave: first bit presented at cs fall, next bit after each sclk fall.
    always @(negedge cs) begin
        sidx = 0;
        miso = slave_byte[0];
    end
    always @(negedge sclk) begin
        if (!cs) begin
            sidx++;
            if (sidx < 8) miso = slave_byte[sidx];
        end
    end

    // Monitor: reconstruct each frame off the pins and compare with the queue.
    always @(negedge sys_clk) begin
        if (rx_pend) begin
            chk("rx_data", 32'(dut.u_spi.rx_data), 32'(rx_exp));
            rx_pend = 1'b0;
        end
        if (rstn) begin
            in_frame = 1'b0;
        end else begin
            if (prev_cs && !cs) begin
                in_frame = 1'b1;
                bits     = 8'h00;
                nrise    = 0;
                low_cnt  = 0;
            end
            if (in_frame && !cs) low_cnt++;
            if (in_frame && !prev_sclk && sclk) begin
                if (nrise < 8) bits[nrise] = mosi;
                nrise++;
            end
            if (in_frame && prev_sclk && !sclk && nrise >= 1 && nrise <= 8)
                chk("mosi_stable_high", 32'(prev_mosi), 32'(bits[nrise-1]));
            if (in_frame && !prev_cs && cs) begin
                in_frame = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame %0h expected none", bits);
                end else begin
                    frame_t f;
                    f = sb.pop_front();
                    chk("mosi_byte", 32'(bits), 32'(f.tx));
                    chk("sclk_rises", 32'(nrise), 32'd8);
                    chk("cs_low_cycles", 32'(low_cnt), 32'd65);
                    rx_exp  = f.rx;
                    rx_pend = 1'b1;
                end
            end
        end
        prev_cs   = cs;
        prev_sclk = sclk;
        prev_mosi = mosi;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #2;
    endtask

    task automatic pulse(input logic do_up, input logic do_st);
        if (do_up) up = 1'b0;
        if (do_st) t_start = 1'b0;
        tick(1);
        up = 1'b1;
        t_start = 1'b1;
        tick(6);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame || rx_pend) && n < 300) begin
            tick(1);
            n++;
        end
        tick(2);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
        end
    endtask

    initial begin
        // reset
        rstn = 1'b1;
        tick(2);
        rstn = 1'b0;
        #1;
        chk("reset_led", 32'(led), 32'h01);
        chk("reset_cs", 32'(cs), 32'd1);
        chk("reset_sclk", 32'(sclk), 32'd0);
        chk("reset_mosi", 32'(mosi), 32'd0);
        chk("reset_rx", 32'(dut.u_spi.rx_data), 32'h00);
        tick(2);

        // single 1-cycle pulse advances once
        pulse(1'b1, 1'b0);
        chk("adv_one", 32'(led), 32'h02);
        // five more wrap around back to bit 0
        repeat (4) pulse(1'b1, 1'b0);
        chk("adv_bit5", 32'(led), 32'h20);
        pulse(1'b1, 1'b0);
        chk("adv_wrap", 32'(led), 32'h01);
        // long hold is a single press
        up = 1'b0;
        tick(20);
        chk("hold_low", 32'(led), 32'h02);
        up = 1'b1;
        tick(6);
        chk("hold_release", 32'(led), 32'h02);
        repeat (5) pulse(1'b1, 1'b0);
        chk("back_to_one", 32'(led), 32'h01);

        // transmit 000001, slave answers A5
        slave_byte = 8'hA5;
        sb.push_back('{tx: 8'h01, rx: 8'hA5});
        pulse(1'b0, 1'b1);
        wait_done("tx_a5");

        // busy: second start press mid-frame is dropped
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("led_04", 32'(led), 32'h04);
        slave_byte = 8'h3C;
        sb.push_back('{tx: 8'h04, rx: 8'h3C});
        pulse(1'b0, 1'b1);
        tick(20);
        pulse(1'b0, 1'b1);
        wait_done("busy");
        tick(100);
        chk("busy_idle_cs", 32'(cs), 32'd1);

        // simultaneous up + start: frame carries old pattern
        pulse(1'b1, 1'b0);
        slave_byte = 8'h81;
        sb.push_back('{tx: 8'h08, rx: 8'h81});
        pulse(1'b1, 1'b1);
        chk("simul_led", 32'(led), 32'h10);
        wait_done("simul");

        // reset mid-frame after the 3rd sclk rise
        pulse(1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (!(in_frame && nrise >= 3) && n < 300) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL abort_wait: got %0d rises expected 3", nrise);
            end
        end
        @(posedge sys_clk);
        #2 rstn = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_led", 32'(led), 32'h01);
        #1 rstn = 1'b0;
        tick(4);
        slave_byte = 8'h5A;
        sb.push_back('{tx: 8'h01, rx: 8'h5A});
        pulse(1'b0, 1'b1);
        wait_done("after_abort");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/runner_master.md
Name: runner_master

Overview:
- Running-light controller with an SPI master link to a remote LED slave.
- Holds a 6-bit one-hot LED pattern and shows it on led.
- Active-low button "up" advances (rotates) the pattern by one position.
- Active-low button "t_start" sends the current pattern as an 8-bit SPI frame (mode 0, LSB first) and captures the byte returned on miso.

Parameters:
- REG_WIDTH, 8, SPI frame length in bits.
- LED_WIDTH, 6, width of the pattern and of led; must be <= REG_WIDTH.
- CLK_DIV, 4, sys_clk cycles per SCLK half-period; must be >= 1.

Ports:
- sys_clk  in  1  single system clock; all logic on the rising edge.
- rstn  in  1  synchronous reset, active-high: logic 1 resets on the next rising sys_clk edge.
- t_start  in  1  start button, active-low, asynchronous; idles at 1.
- up  in  1  advance button, active-low, asynchronous; idles at 1.
- led  out  LED_WIDTH  current pattern.
- cs  out  1  SPI chip select, active-low.
- sclk  out  1  SPI clock, idles low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.

Behaviour:
- Reset values:
  - led = 6'b000001; cs = 1; sclk = 0; mosi = 0.
  - Internal receive register rx_data = 0.
  - Button synchronizer flops = 1; FSM = IDLE.
- Button inputs:
  - Each button passes through a 2-flop synchronizer, then an edge detector.
  - A press is the 1->0 transition of the synchronized signal. A 1-cycle-wide low pulse must still register.
  - Holding a button low produces exactly one press.
- up press: led rotates left by one (bit5 wraps to bit0).
  - Takes effect on the 3rd rising edge after up is sampled low.
  - Allowed in any FSM state. The frame already in flight is unaffected.
- SPI FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
  - IDLE: cs = 1, sclk = 0. A t_start press loads tx_shift = {zero-extend, led} and moves to LOAD.
  - LOAD (1 cycle): cs = 0, mosi = tx_shift[0], bit counter = 0; go to SHIFT_LO.
  - SHIFT_LO: sclk = 0 for CLK_DIV cycles, then sclk rises and the FSM enters SHIFT_HI. On that rising edge, sample miso into rx_shift[bit counter].
  - SHIFT_HI: sclk = 1 for CLK_DIV cycles, then sclk falls.
    - If bit counter = REG_WIDTH-1: go to DONE.
    - Else: increment the counter, drive mosi = tx_shift[counter], return to SHIFT_LO.
  - DONE (1 cycle): cs = 1, sclk = 0, mosi = 0, rx_data <= rx_shift; go to IDLE.
- Frame timing:
  - Exactly REG_WIDTH sclk rising edges per frame.
  - mosi is stable for the whole high phase of sclk; the slave samples on the rising edge.
  - Frame length = 2 + 2*CLK_DIV*REG_WIDTH cycles; 66 cycles at the defaults.
- t_start presses outside IDLE are ignored (not queued).
- Reset asserted mid-frame: cs returns to 1 and sclk to 0 on the next edge; the frame is abandoned.
- Simultaneous up and t_start presses: the frame carries the pre-rotation pattern.

Decomposition:
- Shared package: FSM state enum; reset constants (LED_RESET = 6'b000001); default REG_WIDTH, LED_WIDTH, CLK_DIV.
- One sub-module, spi_master_core: FSM, clock divider, shift registers, rx_data.
- Top level holds the button synchronizers, edge detectors and the LED rotator.

Test Plan:
- Reset: hold rstn = 1 for 2 cycles -> led = 000001, cs = 1, sclk = 0, mosi = 0.
- Advance: one 1-cycle low pulse on up -> led = 000010 three cycles later. Six pulses -> back to 000001 (wrap). Holding up low for 20 cycles -> exactly one advance.
- Transmit: led = 000001, 1-cycle t_start pulse -> cs falls. mosi over 8 sclk rising edges = 1,0,0,0,0,0,0,0. cs rises after 66 cycles.
- Receive: slave model drives miso LSB-first with 8'hA5 -> rx_data = 8'hA5 after DONE.
- Busy: second t_start press mid-frame -> ignored; exactly 8 sclk edges, then IDLE.
- Reset mid-frame: rstn = 1 after the 3rd sclk edge -> next edge cs = 1, sclk = 0, led = 000001; a later t_start runs a full clean frame.
